serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder/subtractor sequencer.
- Time-shares one instance of the 1-bit full-adder cell (sum1: A, B, C_in -> Q, C_out) across N clock cycles, LSB first, with the carry held in a flip-flop between bits.
- Gives the datapath a multi-bit add/subtract at the area cost of a single full-adder cell plus shift registers and a counter.
- Start/Busy/Done handshake to the surrounding control.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- CW, 4, bit-counter width, ceil(log2(N)) minimum; must satisfy 2**CW >= N.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- Start  input  1  request an operation; sampled only when not Busy.
- Sub  input  1  0 = A+B+C_in; 1 = A-B (C_in ignored). Sampled with Start.
- A  input  N  operand A; sampled with Start.
- B  input  N  operand B; sampled with Start.
- C_in  input  1  carry-in for add; sampled with Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  single-cycle pulse: Q, C_out and V are valid.
- Q  output  N  result; held until the next accepted Start.
- C_out  output  1  final carry; for Sub, 1 = no borrow (A >= B unsigned).
- V  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (RST=1 at an edge), regardless of state:
  - state=IDLE, Busy=0, Done=0, Q=0, C_out=0, V=0.
  - Operand shift registers, carry FF and counter cleared.
- IDLE or DONE, Start=1 at edge k:
  - Load shift register SA<=A.
  - Load shift register SB<= Sub ? ~B : B.
  - Carry FF <= Sub ? 1 : C_in.
  - Counter <= 0, state <= RUN.
  - Q, C_out and V are NOT cleared at load; they change only during RUN.
- IDLE, Start=0: stay IDLE.
- DONE, Start=0: next edge -> IDLE.
- RUN, each edge:
  - Full-adder cell inputs: SA[0], SB[0], carry FF.
  - Q shifts right by one with the cell sum entering Q[N-1].
  - Carry FF <= cell carry.
  - SA and SB shift right by one.
  - Counter increments.
- RUN, on the edge with counter==N-1:
  - C_out <= cell carry.
  - V <= cell carry XOR carry FF (carry FF holds the carry into the MSB).
  - state <= DONE.
- Outputs by state: Busy=1 iff RUN. Done=1 iff DONE (exactly one cycle).
- Latency: Start sampled at edge k; Done high in the cycle following edge k+N; Q complete at that point.
- Throughput: with Start held high, a new operation is accepted in the Done cycle. Back-to-back period is N+1 cycles.
- Start while RUN: ignored, no queueing. Operands changing during RUN have no effect.
- Arithmetic is modulo 2**N. No sign extension; Q is exactly N bits.
- Reset mid-RUN: operation aborted, Done is not asserted, outputs go to their reset values.
- Start and RST high at the same edge: reset wins.
- Counter wrap: cannot occur; RUN always exits at N-1.

Test Plan (N=8):
- Reset: assert RST 2 cycles with Start=1 -> Busy=0, Done=0, Q=0x00, C_out=0, V=0; no operation started.
- Add: A=0x5A, B=0x3C, C_in=0, Sub=0, pulse Start -> Busy high 8 cycles; Done on cycle 8 after Start edge; Q=0x96, C_out=0, V=1.
- Add with carry and wrap:
  - A=0xFF, B=0x01, C_in=0 -> Q=0x00, C_out=1, V=0.
  - Then A=0x00, B=0x00, C_in=1 -> Q=0x01, C_out=0, V=0.
- Subtract:
  - A=0x10, B=0x20, Sub=1 -> Q=0xF0, C_out=0, V=0.
  - A=0x80, B=0x01, Sub=1 -> Q=0x7F, C_out=1, V=1.
- Handshake:
  - Start pulsed again mid-RUN with different A/B -> ignored; first result is unchanged.
  - Start held high continuously -> Done every 9 cycles.
  - Q is stable between Done and the next accepted Start.
- Abort: assert RST at bit 4 of A=0x5A+B=0x3C -> no Done pulse, Q=0x00; a subsequent Start completes normally with Q=0x96.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between the serial adder and its controller.
// The master issues Start with operands; the slave reports Busy/Done and the result.
interface serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         Start;
  logic         Sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_in;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Q;
  logic         C_out;
  logic         V;

  modport master (
    output Start, Sub, A, B, C_in,
    input  Busy, Done, Q, C_out, V
  );

  modport slave (
    input  Start, Sub, A, B, C_in,
    output Busy, Done, Q, C_out, V
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit add/subtract: one full-adder cell reused LSB-first over N cycles.
// Latency N+1 cycles from Start to Done; Start is ignored while Busy (no queueing).
module sum1 (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Q,
  output logic C_out
);
  assign Q     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4   // 2**CW must be >= N
) (
  input  logic               CLK,
  input  logic               RST,
  serial_add_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sa, sb, q_reg;
  logic           cy, cout_reg, v_reg;
  logic [CW-1:0]  cnt;
  logic           load, step, last;
  logic           fa_q, fa_co;

  sum1 u_fa (
    .A     (sa[0]),
    .B     (sb[0]),
    .C_in  (cy),
    .Q     (fa_q),
    .C_out (fa_co)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Accepting Start here gives the N+1 cycle back-to-back period.
        if (bus.Start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sa       <= '0;
      sb       <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      q_reg    <= '0;
      cout_reg <= 1'b0;
      v_reg    <= 1'b0;
    end else if (load) begin
      // Subtraction is A + ~B + 1; the result registers are left untouched here.
      sa  <= bus.A;
      sb  <= bus.Sub ? ~bus.B : bus.B;
      cy  <= bus.Sub ? 1'b1 : bus.C_in;
      cnt <= '0;
    end else if (step) begin
      q_reg <= {fa_q, q_reg[N-1:1]};
      cy    <= fa_co;
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_reg <= fa_co;
        v_reg    <= fa_co ^ cy;
      end
    end
  end

  assign bus.Busy  = (state == RUN);
  assign bus.Done  = (state == DONE);
  assign bus.Q     = q_reg;
  assign bus.C_out = cout_reg;
  assign bus.V     = v_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (N=8): stimulus pushes expected results,
// a monitor pops and compares on every Done pulse.
module tb_serial_add_ctrl;
  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic         c;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N), .CW(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result_q", 32'(bus.Q), 32'(e.q));
          check("result_cout", 32'(bus.C_out), 32'(e.c));
          check("result_v", 32'(bus.V), 32'(e.v));
        end
      end
    end
  end

  // One-cycle Start pulse; returns at the negedge right after the load edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic sub, input logic push, input exp_t e);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.C_in = cin; bus.Sub = sub; bus.Start = 1'b1;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Checks Done at the current negedge first, then advances up to 'limit' cycles.
  task automatic wait_done(input int limit, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (bus.Done !== 1'b1 && cycles < limit) begin
      if (bus.Busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (bus.Done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_cyc;
    int t0, t1;
    bit seen;

    rst = 1'b1;
    bus.Start = 1'b1; bus.Sub = 1'b0; bus.A = 8'h5A; bus.B = 8'h3C; bus.C_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_q", 32'(bus.Q), 32'h00);
    check("rst_cout", 32'(bus.C_out), 32'd0);
    check("rst_v", 32'(bus.V), 32'd0);
    bus.Start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(bus.Busy), 32'd0);

    // Add with latency/busy-length checks
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, '{8'h96, 1'b0, 1'b1});
    wait_done(20, cyc, busy_cyc);
    check("add_latency", 32'(cyc), 32'd8);
    check("add_busy_len", 32'(busy_cyc), 32'd8);

    start_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0});
    wait_done(20, cyc, busy_cyc);
    start_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, '{8'h01, 1'b0, 1'b0});
    wait_done(20, cyc, busy_cyc);

    // Subtract; Q keeps the previous result through the load edge
    start_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b1, '{8'hF0, 1'b0, 1'b0});
    check("q_held_at_load", 32'(bus.Q), 32'h01);
    wait_done(20, cyc, busy_cyc);
    start_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, '{8'h7F, 1'b1, 1'b1});
    wait_done(20, cyc, busy_cyc);

    // Start mid-RUN with other operands must be ignored
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, '{8'h96, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    bus.A = 8'h11; bus.B = 8'h22; bus.Sub = 1'b1; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(20, cyc, busy_cyc);
    check("midrun_latency", 32'(cyc), 32'd4);
    repeat (5) @(negedge clk);
    check("q_stable_idle", 32'(bus.Q), 32'h96);
    check("idle_no_restart", 32'(bus.Busy), 32'd0);

    // Start held high: three back-to-back ops, Done period 9
    repeat (3) sb_q.push_back('{8'h03, 1'b0, 1'b0});
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h02; bus.C_in = 1'b0; bus.Sub = 1'b0; bus.Start = 1'b1;
    @(negedge clk);
    wait_done(20, cyc, busy_cyc);
    t0 = cyc;
    @(negedge clk);
    wait_done(20, cyc, busy_cyc);
    t1 = cyc + 1;
    check("b2b_period_1", 32'(t1), 32'd9);
    @(negedge clk);
    wait_done(20, cyc, busy_cyc);
    bus.Start = 1'b0;
    check("b2b_period_2", 32'(cyc + 1), 32'd9);
    check("b2b_first_latency", 32'(t0), 32'd8);
    @(negedge clk);
    check("b2b_stopped", 32'(bus.Busy), 32'd0);

    // Abort mid-RUN
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_q", 32'(bus.Q), 32'h00);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.Done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, '{8'h96, 1'b0, 1'b1});
    wait_done(20, cyc, busy_cyc);
    check("after_abort_latency", 32'(cyc), 32'd8);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
